alarm_sequencer: RTL and testbench



---
 rtl/alarm_pkg.sv | 18 +
 rtl/sec_downct.sv | 39 +++
 rtl/alarm_sequencer.sv | 117 +++++++++++
 tb/tb_alarm_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam int unsigned RING_SEC_D    = 300;
  localparam int unsigned SNOOZE_SEC_D  = 540;
  localparam int unsigned MAX_SNOOZES_D = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sec_downct.sv
// Loadable down counter for seconds; saturates at zero, clear beats load beats dec.
module sec_downct #(
  parameter int unsigned TW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  input  logic          clear,
  output logic [TW-1:0] count,
  output logic          is_one
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == TW'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Turns the raw alarm-match level into a buzzer drive with ring timeout and bounded snoozes.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC    = RING_SEC_D,
  parameter int unsigned SNOOZE_SEC  = SNOOZE_SEC_D,
  parameter int unsigned MAX_SNOOZES = MAX_SNOOZES_D,
  localparam int unsigned TW = $clog2(max_u(RING_SEC, SNOOZE_SEC) + 1),
  localparam int unsigned SW = $clog2(MAX_SNOOZES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          alarm_match,
  input  logic          alarm_on,
  input  logic          snooze,
  output logic          buzz,
  output logic          snoozing,
  output logic [SW-1:0] snooze_cnt,
  output logic [TW-1:0] timer
);

  alarm_state_t  state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          match_q;
  logic          match_rise;

  logic          t_load, t_dec, t_clear, t_is_one;
  logic [TW-1:0] t_load_val;
  logic [TW-1:0] t_count;

  // match_q resets high so a match already present at reset is not seen as an edge.
  assign match_rise = alarm_match & ~match_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    t_clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (alarm_on && match_rise) begin
          state_d    = RING;
          t_load     = 1'b1;
          t_load_val = TW'(RING_SEC);
          cnt_d      = '0;
        end
      end
      RING: begin
        if (!alarm_on) begin
          state_d = IDLE;
          t_clear = 1'b1;
        end else if (snooze && (cnt_q < SW'(MAX_SNOOZES))) begin
          // Snooze outranks the final tick so a last-second press still snoozes.
          state_d    = SNOOZE;
          t_load     = 1'b1;
          t_load_val = TW'(SNOOZE_SEC);
          cnt_d      = cnt_q + 1'b1;
        end else if (tick && t_is_one) begin
          state_d = IDLE;
          t_clear = 1'b1;
        end else if (tick) begin
          t_dec = 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_on) begin
          state_d = IDLE;
          t_clear = 1'b1;
        end else if (tick && t_is_one) begin
          state_d    = RING;
          t_load     = 1'b1;
          t_load_val = TW'(RING_SEC);
        end else if (tick) begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= alarm_match;
    end
  end

  sec_downct #(
    .TW(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .clear    (t_clear),
    .count    (t_count),
    .is_one   (t_is_one)
  );

  assign buzz       = (state_q == RING);
  assign snoozing   = (state_q == SNOOZE);
  assign snooze_cnt = cnt_q;
  assign timer      = t_count;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with short ring/snooze periods.
module tb_alarm_sequencer;

  localparam int unsigned RS = 3;
  localparam int unsigned SS = 4;
  localparam int unsigned MS = 2;

  logic       clk = 1'b0;
  logic       rst, tick, alarm_match, alarm_on, snooze;
  logic       buzz, snoozing;
  logic [1:0] snooze_cnt;
  logic [2:0] timer;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alarm_sequencer #(
    .RING_SEC    (RS),
    .SNOOZE_SEC  (SS),
    .MAX_SNOOZES (MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .alarm_match (alarm_match),
    .alarm_on    (alarm_on),
    .snooze      (snooze),
    .buzz        (buzz),
    .snoozing    (snoozing),
    .snooze_cnt  (snooze_cnt),
    .timer       (timer)
  );

  // Apply one-cycle pulses, take one clock edge, land 1 ns after it.
  task automatic cyc(input logic t, input logic s);
    tick   = t;
    snooze = s;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    snooze = 1'b0;
  endtask

  task automatic check(input string tag, input logic eb, input logic es,
                       input logic [1:0] ec, input logic [2:0] et);
    nvec++;
    assert (buzz === eb) else begin
      nerr++;
      $error("FAIL %s buzz got %0b exp %0b", tag, buzz, eb);
    end
    nvec++;
    assert (snoozing === es) else begin
      nerr++;
      $error("FAIL %s snoozing got %0b exp %0b", tag, snoozing, es);
    end
    nvec++;
    assert (snooze_cnt === ec) else begin
      nerr++;
      $error("FAIL %s snooze_cnt got %0d exp %0d", tag, snooze_cnt, ec);
    end
    nvec++;
    assert (timer === et) else begin
      nerr++;
      $error("FAIL %s timer got %0d exp %0d", tag, timer, et);
    end
  endtask

  task automatic new_event();
    alarm_match = 1'b0;
    cyc(1'b0, 1'b0);
    alarm_match = 1'b1;
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    tick        = 1'b0;
    snooze      = 1'b0;
    alarm_match = 1'b1;
    alarm_on    = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset", 1'b0, 1'b0, 2'd0, 3'd0);
    rst = 1'b0;

    // Match held high across reset must not trigger.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    check("no_false_trig", 1'b0, 1'b0, 2'd0, 3'd0);

    // Plain ring to auto-silence.
    new_event();
    check("ring_start", 1'b1, 1'b0, 2'd0, 3'd3);
    cyc(1'b1, 1'b0);
    check("ring_t2", 1'b1, 1'b0, 2'd0, 3'd2);
    new_event();
    check("rise_in_ring_ignored", 1'b1, 1'b0, 2'd0, 3'd2);
    cyc(1'b1, 1'b0);
    check("ring_t1", 1'b1, 1'b0, 2'd0, 3'd1);
    cyc(1'b1, 1'b0);
    check("auto_silence", 1'b0, 1'b0, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    check("no_retrigger", 1'b0, 1'b0, 2'd0, 3'd0);

    // Snooze then return to ring.
    new_event();
    check("ring2_start", 1'b1, 1'b0, 2'd0, 3'd3);
    cyc(1'b0, 1'b1);
    check("snooze1", 1'b0, 1'b1, 2'd1, 3'd4);
    cyc(1'b0, 1'b1);
    check("snooze_in_snooze_ignored", 1'b0, 1'b1, 2'd1, 3'd4);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    check("snooze_t1", 1'b0, 1'b1, 2'd1, 3'd1);
    cyc(1'b1, 1'b0);
    check("snooze_to_ring", 1'b1, 1'b0, 2'd1, 3'd3);

    // Second snooze, then third is refused.
    cyc(1'b0, 1'b1);
    check("snooze2", 1'b0, 1'b1, 2'd2, 3'd4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    check("ring_after_snooze2", 1'b1, 1'b0, 2'd2, 3'd3);
    cyc(1'b0, 1'b1);
    check("snooze3_ignored", 1'b1, 1'b0, 2'd2, 3'd3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    check("silent_cnt_held", 1'b0, 1'b0, 2'd2, 3'd0);

    // Snooze coincident with the final tick.
    new_event();
    check("ring3_start", 1'b1, 1'b0, 2'd0, 3'd3);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("ring3_t1", 1'b1, 1'b0, 2'd0, 3'd1);
    cyc(1'b1, 1'b1);
    check("snooze_beats_tick", 1'b0, 1'b1, 2'd1, 3'd4);

    // Drop alarm_on mid-snooze; a rise while off is ignored.
    cyc(1'b1, 1'b0);
    check("snooze_t3", 1'b0, 1'b1, 2'd1, 3'd3);
    alarm_on = 1'b0;
    cyc(1'b0, 1'b0);
    check("off_mid_snooze", 1'b0, 1'b0, 2'd1, 3'd0);
    new_event();
    check("rise_while_off", 1'b0, 1'b0, 2'd1, 3'd0);

    // Reset mid-ring.
    alarm_on = 1'b1;
    new_event();
    cyc(1'b1, 1'b0);
    check("ring4_t2", 1'b1, 1'b0, 2'd0, 3'd2);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    check("rst_mid_ring", 1'b0, 1'b0, 2'd0, 3'd0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    check("after_rst_no_trig", 1'b0, 1'b0, 2'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
